// File: rtl/stopwatch_pkg.sv
// Shared stopwatch definitions: record width, default lap buffer depth and
// the lap queue handshake FSM encoding.
package stopwatch_pkg;

  localparam int unsigned RecordWidth  = 32;
  localparam int unsigned DefaultDepth = 8;

  typedef logic [RecordWidth-1:0] record_t;

  typedef enum logic [2:0] {
    StIdle,
    StIssue,
    StWaitAck,
    StWaitDone,
    StClear
  } lrq_state_e;

endpackage

// File: rtl/record_fifo.sv
// Lap record storage: circular buffer with wrapping pointers, occupancy count
// and full/empty flags. Flush has priority over push and pop.
module record_fifo
  import stopwatch_pkg::*;
#(
  parameter int unsigned DEPTH = DefaultDepth
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  record_t                push_data,
  output record_t                head_data,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  record_t         mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count_q;

  // Power-of-two depth lets the pointers wrap by plain overflow.
  always_ff @(posedge clock) begin
    if (reset || flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop) begin
        count_q <= count_q + CW'(1);
      end else if (!push && pop) begin
        count_q <= count_q - CW'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (push && !flush) mem[wr_ptr] <= push_data;
  end

  assign head_data = mem[rd_ptr];
  assign count     = count_q;
  assign full      = (count_q == CW'(DEPTH));
  assign empty     = (count_q == '0);

endmodule

// File: rtl/lap_record_queue.sv
// Buffers lap timestamps and feeds them one at a time to the LCD bridge,
// with busy-based acknowledge, timeout re-issue and flush/clear handling.
module lap_record_queue
  import stopwatch_pkg::*;
#(
  parameter int unsigned DEPTH       = DefaultDepth,
  parameter int unsigned ACK_TIMEOUT = 15
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   capture,
  input  logic [31:0]            record_in,
  input  logic                   clear_req,
  input  logic                   lcd_busy,
  output logic                   insert,
  output logic [31:0]            new_record,
  output logic                   clear,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty,
  output logic                   overflow
);

  localparam int unsigned TimerW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [TimerW-1:0] TimerLast = TimerW'(ACK_TIMEOUT - 1);

  lrq_state_e        state_q, state_d;
  logic [TimerW-1:0] timer_q, timer_d;
  logic              op_clear_q, op_clear_d;
  logic              entry_valid_q, entry_valid_d;
  logic              pending_q, pending_d;
  logic              overflow_q, overflow_d;
  record_t           new_record_q, new_record_d;

  logic    fifo_push, fifo_pop, load_head, pending_drop;
  record_t head_data;

  record_fifo #(
    .DEPTH (DEPTH)
  ) u_record_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (fifo_push),
    .pop       (fifo_pop),
    .flush     (clear_req),
    .push_data (record_in),
    .head_data (head_data),
    .count     (count),
    .full      (full),
    .empty     (empty)
  );

  always_comb begin
    state_d      = state_q;
    timer_d      = timer_q;
    op_clear_d   = op_clear_q;
    load_head    = 1'b0;
    fifo_pop     = 1'b0;
    insert       = 1'b0;
    clear        = 1'b0;
    pending_drop = 1'b0;
    case (state_q)
      StIdle: begin
        if (!lcd_busy) begin
          // A same-cycle clear_req counts as pending so a doomed entry is never issued.
          if (pending_q || clear_req) begin
            state_d = StClear;
          end else if (!empty) begin
            state_d   = StIssue;
            load_head = 1'b1;
          end
        end
      end
      StIssue: begin
        if (!entry_valid_q) begin
          state_d = StIdle;
        end else if (!lcd_busy) begin
          insert     = 1'b1;
          state_d    = StWaitAck;
          timer_d    = '0;
          op_clear_d = 1'b0;
        end
      end
      StClear: begin
        if (!lcd_busy) begin
          clear        = 1'b1;
          pending_drop = 1'b1;
          state_d      = StWaitAck;
          timer_d      = '0;
          op_clear_d   = 1'b1;
        end
      end
      StWaitAck: begin
        if (lcd_busy) begin
          state_d = StWaitDone;
        end else if (timer_q == TimerLast) begin
          if (op_clear_q) begin
            state_d = StClear;
          end else if (entry_valid_q) begin
            state_d   = StIssue;
            load_head = 1'b1;
          end else begin
            state_d = StIdle;
          end
        end else begin
          timer_d = timer_q + TimerW'(1);
        end
      end
      StWaitDone: begin
        if (!lcd_busy) begin
          state_d  = StIdle;
          fifo_pop = !op_clear_q && entry_valid_q;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // A pop in the same cycle frees the slot, so a capture at full is still taken.
  assign fifo_push = capture && !clear_req && (!full || fifo_pop);

  always_comb begin
    overflow_d    = overflow_q;
    pending_d     = pending_q;
    entry_valid_d = entry_valid_q;
    new_record_d  = new_record_q;
    if (clear_req) begin
      overflow_d    = 1'b0;
      pending_d     = 1'b1;
      entry_valid_d = 1'b0;
    end else begin
      if (capture && full && !fifo_pop) overflow_d = 1'b1;
      if (pending_drop) pending_d = 1'b0;
      if (load_head) begin
        entry_valid_d = 1'b1;
      end else if (fifo_pop) begin
        entry_valid_d = 1'b0;
      end
    end
    if (load_head) new_record_d = head_data;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= StIdle;
      timer_q       <= '0;
      op_clear_q    <= 1'b0;
      entry_valid_q <= 1'b0;
      pending_q     <= 1'b0;
      overflow_q    <= 1'b0;
      new_record_q  <= '0;
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      op_clear_q    <= op_clear_d;
      entry_valid_q <= entry_valid_d;
      pending_q     <= pending_d;
      overflow_q    <= overflow_d;
      new_record_q  <= new_record_d;
    end
  end

  assign new_record = new_record_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_lap_record_queue.sv
// Bench for lap_record_queue: queue-based reference model plus an LCD bridge
// responder; directed scenarios followed by randomized traffic.
module tb_lap_record_queue;

  localparam int unsigned DEPTH       = 8;
  localparam int unsigned ACK_TIMEOUT = 15;
  localparam int unsigned CW          = $clog2(DEPTH) + 1;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          capture = 1'b0;
  logic [31:0]   record_in = '0;
  logic          clear_req = 1'b0;
  logic          lcd_busy = 1'b0;
  logic          insert, clear, full, empty, overflow;
  logic [31:0]   new_record;
  logic [CW-1:0] count;

  always #5 clock = ~clock;

  lap_record_queue #(
    .DEPTH       (DEPTH),
    .ACK_TIMEOUT (ACK_TIMEOUT)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .capture    (capture),
    .record_in  (record_in),
    .clear_req  (clear_req),
    .lcd_busy   (lcd_busy),
    .insert     (insert),
    .new_record (new_record),
    .clear      (clear),
    .count      (count),
    .full       (full),
    .empty      (empty),
    .overflow   (overflow)
  );

  int total = 0;
  int bad   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference model: records accepted but not yet consumed by the LCD.
  logic [31:0] mq[$];
  bit          m_ovf = 1'b0;

  // LCD bridge responder: 0 idle, 1 ack delay, 2 busy hold, 3 ignoring.
  int  rphase = 0;
  int  rcnt   = 0;
  bit  r_op_ins, r_live, r_busy;
  bit  force_busy  = 1'b0;
  bit  force_noack = 1'b0;
  bit  rand_mode   = 1'b0;
  int  ack_d  = 1;
  int  hold_h = 2;
  int  n_ins  = 0;
  int  n_clr  = 0;

  task automatic tick(input bit cap, input logic [31:0] rec, input bit clr, input bit rst);
    bit pop_now = 1'b0;
    check_eq("count", 32'(count), 32'(mq.size()));
    check_eq("full", 32'(full), 32'(mq.size() == DEPTH));
    check_eq("empty", 32'(empty), 32'(mq.size() == 0));
    check_eq("overflow", 32'(overflow), 32'(m_ovf));
    if (insert || clear) begin
      check_eq("pulse_while_busy", 32'(lcd_busy), 0);
      check_eq("insert_and_clear", 32'(insert && clear), 0);
    end
    if (insert) begin
      n_ins++;
      check_eq("insert_nonempty", 32'(mq.size() != 0), 1);
      if (mq.size() != 0) check_eq("insert_data", new_record, mq[0]);
    end
    if (clear) n_clr++;

    case (rphase)
      1: begin
        if (rcnt <= 1) begin
          r_busy = 1'b1;
          rphase = 2;
          rcnt   = rand_mode ? int'($urandom_range(6, 1)) : hold_h;
        end else begin
          rcnt--;
        end
      end
      2: begin
        if (rcnt <= 1) begin
          r_busy  = 1'b0;
          rphase  = 0;
          pop_now = r_op_ins && r_live;
        end else begin
          rcnt--;
        end
      end
      default: ;
    endcase

    if (insert || clear) begin
      r_op_ins = insert;
      r_live   = insert;
      if (force_noack || (rand_mode && $urandom_range(9, 0) == 0)) begin
        rphase = 3;
      end else begin
        rphase = 1;
        rcnt   = rand_mode ? int'($urandom_range(4, 1)) : ack_d;
      end
    end

    if (rst) begin
      mq.delete();
      m_ovf  = 1'b0;
      rphase = 0;
      r_busy = 1'b0;
      r_live = 1'b0;
    end else if (clr) begin
      mq.delete();
      m_ovf  = 1'b0;
      r_live = 1'b0;
    end else begin
      if (pop_now) void'(mq.pop_front());
      if (cap) begin
        if (mq.size() < DEPTH) mq.push_back(rec);
        else m_ovf = 1'b1;
      end
    end

    reset     = rst;
    capture   = cap;
    record_in = rec;
    clear_req = clr;
    lcd_busy  = r_busy | force_busy;
    @(negedge clock);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic wait_insert(input string tag, input int budget, output int waited);
    waited = -1;
    for (int i = 0; i < budget; i++) begin
      if (insert) begin
        waited = i;
        break;
      end
      tick(1'b0, 32'h0, 1'b0, 1'b0);
    end
    if (waited < 0 && insert) waited = budget;
    check_eq(tag, 32'(waited >= 0), 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int w, c0, i0;
    @(negedge clock);
    tick(1'b0, 32'h0, 1'b0, 1'b1);
    check_eq("rst_insert", 32'(insert), 0);
    check_eq("rst_clear", 32'(clear), 0);
    check_eq("rst_new_record", new_record, 0);
    check_eq("rst_count", 32'(count), 0);
    check_eq("rst_empty", 32'(empty), 1);
    check_eq("rst_overflow", 32'(overflow), 0);
    idle(2);

    // Single record, LCD busy for five cycles.
    hold_h = 5;
    tick(1'b1, 32'h0001_1234, 1'b0, 1'b0);
    wait_insert("t1_insert_seen", 10, w);
    check_eq("t1_latency", 32'(w), 1);
    check_eq("t1_new_record", new_record, 32'h0001_1234);
    idle(12);
    check_eq("t1_drained", 32'(count), 0);
    hold_h = 2;

    // Nine captures with LCD held busy, then release.
    force_busy = 1'b1;
    tick(1'b0, 32'h0, 1'b0, 1'b0);
    for (int k = 0; k < 9; k++) tick(1'b1, 32'hA000_0000 + 32'(k), 1'b0, 1'b0);
    check_eq("t2_count", 32'(count), 8);
    check_eq("t2_full", 32'(full), 1);
    check_eq("t2_overflow", 32'(overflow), 1);
    i0 = n_ins;
    force_busy = 1'b0;
    idle(150);
    check_eq("t2_inserts", 32'(n_ins - i0), 8);
    check_eq("t2_empty", 32'(empty), 1);
    check_eq("t2_ovf_sticky", 32'(overflow), 1);

    // Capture and clear_req together with three entries stored.
    force_busy = 1'b1;
    for (int k = 0; k < 3; k++) tick(1'b1, 32'hB000_0000 + 32'(k), 1'b0, 1'b0);
    check_eq("t3_count3", 32'(count), 3);
    c0 = n_clr;
    i0 = n_ins;
    tick(1'b1, 32'hBEEF_0000, 1'b1, 1'b0);
    check_eq("t3_flushed", 32'(count), 0);
    check_eq("t3_ovf_cleared", 32'(overflow), 0);
    force_busy = 1'b0;
    idle(40);
    check_eq("t3_one_clear", 32'(n_clr - c0), 1);
    check_eq("t3_no_insert", 32'(n_ins - i0), 0);

    // LCD never acknowledges: insert re-issued after the timeout.
    force_noack = 1'b1;
    tick(1'b1, 32'hC0DE_0001, 1'b0, 1'b0);
    wait_insert("t4_first_seen", 10, w);
    tick(1'b0, 32'h0, 1'b0, 1'b0);
    wait_insert("t4_reissue_seen", 40, w);
    check_eq("t4_interval", 32'(w + 1), ACK_TIMEOUT + 1);
    check_eq("t4_count", 32'(count), 1);
    check_eq("t4_data", new_record, 32'hC0DE_0001);
    force_noack = 1'b0;
    idle(60);
    check_eq("t4_drained", 32'(count), 0);

    // clear_req while the LCD is busy with an insert.
    hold_h = 8;
    tick(1'b1, 32'hD00D_0001, 1'b0, 1'b0);
    wait_insert("t5_insert_seen", 10, w);
    idle(3);
    check_eq("t5_busy", 32'(lcd_busy), 1);
    c0 = n_clr;
    tick(1'b0, 32'h0, 1'b1, 1'b0);
    check_eq("t5_count0", 32'(count), 0);
    idle(30);
    check_eq("t5_one_clear", 32'(n_clr - c0), 1);
    check_eq("t5_no_underflow", 32'(count), 0);
    hold_h = 2;

    // Reset in the middle of waiting for acknowledge.
    force_noack = 1'b1;
    tick(1'b1, 32'hE000_0001, 1'b0, 1'b0);
    wait_insert("t6_insert_seen", 10, w);
    idle(2);
    i0 = n_ins;
    tick(1'b0, 32'h0, 1'b0, 1'b1);
    check_eq("t6_insert", 32'(insert), 0);
    check_eq("t6_clear", 32'(clear), 0);
    check_eq("t6_new_record", new_record, 0);
    check_eq("t6_count", 32'(count), 0);
    check_eq("t6_overflow", 32'(overflow), 0);
    force_noack = 1'b0;
    idle(30);
    check_eq("t6_no_insert", 32'(n_ins - i0), 0);

    // Randomized traffic.
    rand_mode = 1'b1;
    for (int k = 0; k < 2000; k++) begin
      tick($urandom_range(3, 0) == 0, $urandom, $urandom_range(79, 0) == 0, 1'b0);
    end
    rand_mode = 1'b0;
    idle(250);
    check_eq("rand_drained", 32'(count), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
